conv_y_checker: RTL and testbench

Built-in self-test receiver for the `y` output stream of a convolution block. It sits downstream of the conv's `m_data_out_y`/`m_valid_y`/`m_ready_y` port and acts as the consumer end of that valid/ready link. It optionally throttles `ready` with an LFSR, fetches each expected value from an external synchronous ROM, and compares every accepted beat. It reports the error count, the index of the first mismatch, pass/fail, and a stall-timeout flag.

---
 rtl/conv_y_checker.sv | 131 +++++++++++++
 tb/tb_conv_y_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_y_checker.sv
// Self-test receiver for the conv block's y stream: consumes beats over valid/ready,
// compares each against an external expected-value ROM and reports error statistics.
module conv_y_checker #(
    parameter int          WIDTH     = 8,
    parameter int          NUMOUT    = 6250,
    parameter int          ADDRW     = 13,
    parameter int          TIMEOUT   = 1024,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             throttle_en,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    output logic [ADDRW-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [15:0]      err_count,
    output logic [ADDRW-1:0] first_err_idx,
    output logic [ADDRW:0]   beat_count
);

    localparam int STALLW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [ADDRW-1:0]  idx;
    logic [ADDRW-1:0]  cmp_idx;
    logic [WIDTH-1:0]  y_q;
    logic              cmp_v;
    logic [STALLW-1:0] stall_cnt;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic              launch;
    logic              accept;
    logic              last_beat;
    logic              stall_expired;
    logic              mismatch;

    assign launch        = start && (state == IDLE || state == DONE);
    assign accept        = (state == RUN) && s_valid_y && s_ready_y;
    assign last_beat     = (idx == ADDRW'(NUMOUT - 1));
    assign stall_expired = (stall_cnt == STALLW'(TIMEOUT - 1));
    assign mismatch      = cmp_v && (y_q != exp_data);

    assign exp_addr = idx;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == 16'd0) && !timeout;

    // An accept on the same edge as the watchdog expiry keeps the run alive.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = RUN;
            RUN: begin
                if (accept && last_beat) next_state = DRAIN;
                else if (!accept && stall_expired) next_state = DONE;
            end
            DRAIN:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Fibonacci LFSR, taps 16,14,13,11, shifting right with feedback into the MSB.
    always_comb begin
        lfsr_next = lfsr;
        if (launch) lfsr_next = LFSR_SEED;
        else if (state == RUN) lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            s_ready_y     <= 1'b0;
            lfsr          <= LFSR_SEED;
            idx           <= '0;
            cmp_idx       <= '0;
            cmp_v         <= 1'b0;
            y_q           <= '0;
            stall_cnt     <= '0;
            err_count     <= 16'd0;
            first_err_idx <= '1;
            timeout       <= 1'b0;
            beat_count    <= '0;
        end else begin
            state     <= next_state;
            lfsr      <= lfsr_next;
            s_ready_y <= (next_state == RUN) && (!throttle_en || lfsr_next[0]);
            if (launch) begin
                idx           <= '0;
                cmp_v         <= 1'b0;
                stall_cnt     <= '0;
                err_count     <= 16'd0;
                first_err_idx <= '1;
                timeout       <= 1'b0;
                beat_count    <= '0;
            end else begin
                cmp_v <= accept;
                if (accept) begin
                    y_q        <= s_data_in_y;
                    cmp_idx    <= idx;
                    idx        <= idx + 1'b1;
                    beat_count <= beat_count + 1'b1;
                    stall_cnt  <= '0;
                end else if (state == RUN) begin
                    stall_cnt <= stall_cnt + 1'b1;
                    if (stall_expired) timeout <= 1'b1;
                end
                // The ROM word for cmp_idx arrives together with cmp_v.
                if (mismatch) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    if (first_err_idx == '1) first_err_idx <= cmp_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_y_checker.sv
// Randomized scoreboard bench for conv_y_checker with a cycle reference model and a bench-side ROM.
module tb_conv_y_checker;

    localparam int          WIDTH   = 8;
    localparam int          NUMOUT  = 32;
    localparam int          ADDRW   = 6;
    localparam int          TIMEOUT = 16;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          NONE    = (1 << ADDRW) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             throttle_en = 1'b0;
    logic [WIDTH-1:0] s_data_in_y = '0;
    logic             s_valid_y = 1'b0;
    logic             s_ready_y;
    logic [ADDRW-1:0] exp_addr;
    logic [WIDTH-1:0] exp_data;
    logic             busy, done, pass, timeout;
    logic [15:0]      err_count;
    logic [ADDRW-1:0] first_err_idx;
    logic [ADDRW:0]   beat_count;

    always #5 clk = ~clk;

    conv_y_checker #(
        .WIDTH(WIDTH), .NUMOUT(NUMOUT), .ADDRW(ADDRW), .TIMEOUT(TIMEOUT), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .throttle_en(throttle_en),
        .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
        .exp_addr(exp_addr), .exp_data(exp_data), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .first_err_idx(first_err_idx),
        .beat_count(beat_count)
    );

    logic [WIDTH-1:0] rom [1 << ADDRW];
    always @(posedge clk) exp_data <= rom[exp_addr];

    typedef struct {
        logic             ready;
        logic             busy;
        logic             done;
        logic [ADDRW-1:0] addr;
    } cyc_t;

    typedef struct {
        int errs;
        int first;
        bit to;
        int beats;
        bit pass;
    } res_t;

    cyc_t cyc_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: phase 0 idle, 1 running, 2 final compare, 3 finished
    bit          m_primed = 0;
    int          m_phase = 0;
    bit          m_ready = 0;
    logic [15:0] m_lfsr = SEED;
    int          m_idx = 0, m_stall = 0, m_beats = 0, m_errs = 0, m_first = -1;
    bit          m_to = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    function automatic void pushResult();
        res_t r;
        r.errs  = m_errs;
        r.first = (m_first < 0) ? NONE : m_first;
        r.to    = m_to;
        r.beats = m_beats;
        r.pass  = (m_errs == 0) && !m_to;
        res_q.push_back(r);
    endfunction

    // One clock: drive inputs, queue the outputs expected now, then advance the model
    task automatic tick(input bit rst, input bit st, input bit thr, input bit vld,
                        input logic [WIDTH-1:0] data, output bit acc);
        cyc_t c;
        reset = rst; start = st; throttle_en = thr; s_valid_y = vld; s_data_in_y = data;
        if (m_primed) begin
            c.ready = m_ready;
            c.busy  = (m_phase == 1) || (m_phase == 2);
            c.done  = (m_phase == 3);
            c.addr  = m_idx[ADDRW-1:0];
            cyc_q.push_back(c);
        end
        @(posedge clk);
        acc = 0;
        if (rst) begin
            m_primed = 1; m_phase = 0; m_lfsr = SEED; m_idx = 0; m_stall = 0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (st) begin
                m_phase = 1; m_lfsr = SEED; m_idx = 0; m_stall = 0;
                m_beats = 0; m_errs = 0; m_first = -1; m_to = 0;
            end
        end else if (m_phase == 1) begin
            acc = vld && m_ready;
            m_lfsr = lfsrStep(m_lfsr);
            if (acc) begin
                if (data != rom[m_idx]) begin
                    if (m_errs < 65535) m_errs++;
                    if (m_first < 0) m_first = m_idx;
                end
                m_idx++; m_beats++; m_stall = 0;
                if (m_beats == NUMOUT) m_phase = 2;
            end else if (m_stall == TIMEOUT - 1) begin
                m_to = 1; m_phase = 3; pushResult();
            end else begin
                m_stall++;
            end
        end else begin
            m_phase = 3; pushResult();
        end
        m_ready = (m_phase == 1) && (!thr || m_lfsr[0]);
        #1;
    endtask

    task automatic checkResetState();
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        checkOutput("rst_first_err_idx", 64'(first_err_idx), 64'(NONE));
        checkOutput("rst_beat_count", 64'(beat_count), 64'd0);
        checkOutput("rst_timeout", 64'(timeout), 64'd0);
        checkOutput("rst_pass", 64'(pass), 64'd0);
    endtask

    // thr_mode: 0 off, 1 on, 2 random per cycle; restart_at pulses start mid-run;
    // abort_after asserts reset once that many beats have been accepted
    task automatic applyStimulus(input int thr_mode, input int valid_pct, input int err_pct,
                                 input logic [63:0] err_mask, input int stop_after,
                                 input int restart_at, input int abort_after);
        logic [WIDTH-1:0] beat_data [64];
        bit               acc, v, thr, rst;
        int               sent = 0;
        int               cyc = 0;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 64; i++) begin
            beat_data[i] = rom[i];
            if (err_mask[i]) beat_data[i] = (rom[i] != 8'h7F) ? 8'h7F : 8'h80;
            else if ($urandom_range(1, 100) <= err_pct)
                beat_data[i] = rom[i] ^ WIDTH'($urandom_range(1, 255));
        end
        thr = (thr_mode == 1);
        tick(0, 1, thr, 0, '0, acc);
        while (m_phase != 3 && cyc < 20000) begin
            if (thr_mode == 2) thr = 1'($urandom_range(0, 1));
            v   = (sent < stop_after) && ($urandom_range(1, 100) <= valid_pct);
            d   = v ? beat_data[sent] : WIDTH'($urandom);
            rst = (abort_after >= 0) && (sent == abort_after);
            tick(rst, cyc == restart_at, thr, v, d, acc);
            if (acc) sent++;
            cyc++;
            if (rst) break;
        end
        for (int i = 0; i < 3; i++) tick(0, 0, thr, 0, '0, acc);
    endtask

    cyc_t mon_c;
    res_t mon_r;
    logic prev_done = 1'b0;

    // Monitor: per-cycle handshake/status checks and final results on each rise of done
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_c = cyc_q.pop_front();
            checkOutput("s_ready_y", 64'(s_ready_y), 64'(mon_c.ready));
            checkOutput("busy", 64'(busy), 64'(mon_c.busy));
            checkOutput("done", 64'(done), 64'(mon_c.done));
            checkOutput("exp_addr", 64'(exp_addr), 64'(mon_c.addr));
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (res_q.size() == 0) begin
                checkOutput("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_r = res_q.pop_front();
                checkOutput("err_count", 64'(err_count), 64'(mon_r.errs));
                checkOutput("first_err_idx", 64'(first_err_idx), 64'(mon_r.first));
                checkOutput("timeout", 64'(timeout), 64'(mon_r.to));
                checkOutput("beat_count", 64'(beat_count), 64'(mon_r.beats));
                checkOutput("pass", 64'(pass), 64'(mon_r.pass));
            end
        end
        prev_done <= done;
    end

    initial begin
        bit acc;
        for (int i = 0; i < (1 << ADDRW); i++) rom[i] = WIDTH'($urandom);
        rom[0] = 8'd3; rom[1] = 8'd0; rom[2] = 8'd7; rom[3] = 8'hFE; rom[4] = 8'd5;

        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, '0, acc);
        tick(0, 0, 0, 0, '0, acc);
        checkResetState();

        $display("[TB] clean back-to-back run");
        applyStimulus(0, 100, 0, 64'h0, NUMOUT, -1, -1);
        $display("[TB] beats 1 and 3 corrupted");
        applyStimulus(0, 100, 0, 64'hA, NUMOUT, -1, -1);
        $display("[TB] LFSR throttled run");
        applyStimulus(1, 100, 0, 64'h0, NUMOUT, -1, -1);
        $display("[TB] source stalls after 3 beats");
        applyStimulus(0, 100, 0, 64'h0, 3, -1, -1);
        $display("[TB] reset after 2 accepts, then clean run");
        applyStimulus(0, 100, 0, {64{1'b1}}, NUMOUT, -1, 2);
        checkResetState();
        applyStimulus(0, 100, 0, 64'h0, NUMOUT, -1, -1);
        $display("[TB] start pulsed during run");
        applyStimulus(0, 100, 0, 64'h10, NUMOUT, 5, -1);

        $display("[TB] randomized runs");
        for (int r = 0; r < 10; r++)
            applyStimulus(2, $urandom_range(40, 100), $urandom_range(0, 20), 64'h0,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUMOUT) : NUMOUT,
                          $urandom_range(0, 40), -1);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("pending_results", 64'(res_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
